// File: rtl/tristate_bus_arbiter_pkg.sv
//------------------------------------------------------------------------------
// tristate_arb_pkg
// Shared types and sizing helpers for the tri-state bus arbiter slice.
//   state_t : arbiter FSM encoding (IDLE / GRANT / TURN)
//   idw()   : index width for an N-entry one-hot vector (minimum 1 bit)
//   cnt_w() : width of a counter that must reach max_val inclusive
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tristate_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam int DEF_N_REQ      = 4;
    localparam int DEF_MAX_HOLD   = 4;
    localparam int DEF_TURNAROUND = 1;

    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // max_val >= 1 always yields at least one bit
    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tristate_bus_arbiter_if.sv
//------------------------------------------------------------------------------
// tristate_bus_arbiter_if
// Request/grant bundle between the arbiter and the bus drivers.
//   req      : per-driver level request (driver -> arbiter)
//   grant    : registered one-hot0 data_en per driver (arbiter -> driver)
//   grant_id : index of current owner, 0 when idle
//   bus_busy : |grant
//   modport master : arbiter side
//   modport slave  : driver/requester side
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface tristate_bus_arbiter_if
    import tristate_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) ();

    localparam int IDW = idw(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_id;
    logic             bus_busy;

    modport master (
        input  req,
        output grant,
        output grant_id,
        output bus_busy
    );

    modport slave (
        output req,
        input  grant,
        input  grant_id,
        input  bus_busy
    );

endinterface

`default_nettype wire

// File: rtl/tristate_bus_arbiter_rr_pick.sv
//------------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search: first set bit of req_i scanning upward
// from ptr_i+1 and wrapping modulo N_REQ. The last-served index (ptr_i)
// is scanned last, so it only wins when nobody else asks.
//   req_i   : request vector
//   ptr_i   : index of the most recent owner
//   valid_o : some request is set
//   idx_o   : winning index (0 when valid_o is low)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick
    import tristate_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDW   = idw(N_REQ)
) (
    input  wire logic [N_REQ-1:0] req_i,
    input  wire logic [IDW-1:0]   ptr_i,
    output logic                  valid_o,
    output logic [IDW-1:0]        idx_o
);

    // Scan from the farthest candidate to the nearest so the nearest
    // set bit is the last one written and therefore wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            int             pos;
            logic [IDW-1:0] pos_idx;
            pos = int'(ptr_i) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            pos_idx = IDW'(pos);
            if (req_i[pos_idx]) begin
                valid_o = 1'b1;
                idx_o   = pos_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tristate_bus_arbiter.sv
//------------------------------------------------------------------------------
// tristate_bus_arbiter
// Round-robin owner selection for a shared tri-state bus. Grants are
// registered one-hot0 and drive each driver's data_en directly. An owner
// is released when it drops its request, or after MAX_HOLD cycles if any
// other driver is waiting. Every release is followed by TURNAROUND
// all-zero cycles so two drivers never overlap on the wire.
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : master modport (req in; grant, grant_id, bus_busy out)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tristate_bus_arbiter
    import tristate_arb_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int MAX_HOLD   = DEF_MAX_HOLD,
    parameter int TURNAROUND = DEF_TURNAROUND
) (
    input  wire logic              clk,
    input  wire logic              rst,
    tristate_bus_arbiter_if.master bus
);

    localparam int IDW = idw(N_REQ);
    localparam int HW  = cnt_w(MAX_HOLD);
    localparam int TW  = cnt_w(TURNAROUND);

    localparam logic [HW-1:0]  C_MAX_HOLD = HW'(MAX_HOLD);
    localparam logic [TW-1:0]  C_TURN     = TW'(TURNAROUND);
    localparam logic [IDW-1:0] C_PTR_RST  = IDW'(N_REQ - 1);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDW-1:0]   id_q, id_d;
    logic             busy_q, busy_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [TW-1:0]    turn_q, turn_d;
    logic [IDW-1:0]   ptr_q, ptr_d;

    logic             pick_valid;
    logic [IDW-1:0]   pick_idx;
    logic             release_now;
    logic             turn_last;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr_pick (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // Requests from anyone other than the owner force release once the
    // hold limit is reached; a lone owner keeps the bus indefinitely.
    assign release_now = !bus.req[id_q] ||
                         ((hold_q == C_MAX_HOLD) && (|(bus.req & ~grant_q)));
    assign turn_last   = (turn_q == C_TURN);

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            id_q    <= '0;
            busy_q  <= 1'b0;
            hold_q  <= '0;
            turn_q  <= '0;
            ptr_q   <= C_PTR_RST;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d = TURN;
                end
            end
            TURN: begin
                if (turn_last) begin
                    state_d = pick_valid ? GRANT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / counter next values
    always_comb begin
        grant_d = grant_q;
        id_d    = id_q;
        hold_d  = hold_q;
        turn_d  = turn_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    id_d              = pick_idx;
                    ptr_d             = pick_idx;
                    hold_d            = HW'(1);
                end
            end
            GRANT: begin
                if (release_now) begin
                    grant_d = '0;
                    id_d    = '0;
                    turn_d  = TW'(1);
                end else if (hold_q != C_MAX_HOLD) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            TURN: begin
                if (!turn_last) begin
                    turn_d = turn_q + TW'(1);
                end else if (pick_valid) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    id_d              = pick_idx;
                    ptr_d             = pick_idx;
                    hold_d            = HW'(1);
                end
            end
            default: begin
                grant_d = '0;
                id_d    = '0;
            end
        endcase
        busy_d = |grant_d;
    end

    assign bus.grant    = grant_q;
    assign bus.grant_id = id_q;
    assign bus.bus_busy = busy_q;

endmodule

`default_nettype wire
